fetch_unit: RTL and testbench

- Instruction fetch front end. Produces the `instruction`/`pc` pair consumed by `decoder`.
- Takes the `pc_sel`-driven redirect target back from execute and issues word requests to instruction memory.
- Buffers in-order responses in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirect flush, including discard of responses already in flight.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front end.
// Contents: fetch_state_t (FSM states), fetch_entry_t (FIFO entry), INSTR_NOP.
// FAULT is only ever entered when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        misaligned;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; head visible combinationally, push visible next cycle.
// Ports: push/push_data write, pop removes head (ignored when empty), flush empties (wins over push/pop),
//        head/count/empty describe the current contents. Pushing into a full FIFO without a pop is illegal.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted alongside a pop (count unchanged).
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word requests, buffers in-order responses, hands {instruction, pc} to decode.
// Latency: grant at N, rvalid at N+1, instr_valid at N+2; head outputs are combinational from the FIFO.
// Backpressure: instr_ready low fills the FIFO; requests stop once buffered + live in-flight reaches DEPTH.
// Ports: clk/rst; fetch_en; redirect_valid/redirect_pc from execute; imem_req/imem_addr/imem_gnt request side;
//        imem_rvalid/imem_rdata response side; instr_valid/instr_ready/instruction/pc/instr_misaligned toward decode.
// Macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets enter FAULT and deliver one NOP marked misaligned;
// without it, redirect targets are word-aligned by clearing bits [1:0].
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        instr_misaligned
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t   state;
    fetch_state_t   state_nxt;
    logic [31:0]    fetch_pc;
    logic [31:0]    resp_pc;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  discard;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    committed;
    logic           fifo_empty;
    logic           gnt_fire;
    logic           drop;
    logic           accept;
    logic           push;
    logic [31:0]    target;
    fetch_entry_t   push_data;
    fetch_entry_t   head;

    // Slots already spoken for: buffered entries plus responses that will be kept.
    assign committed = (CW+1)'(fifo_count) + (CW+1)'(outstanding - discard);

    assign imem_req  = (state == RUN) && !redirect_valid
                    && (outstanding < OW'(MAX_OUTSTANDING))
                    && (committed < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign gnt_fire  = imem_req && imem_gnt;

    // Responses for requests issued before a redirect are counted off by discard.
    assign drop   = imem_rvalid && (discard != '0);
    assign accept = imem_rvalid && (discard == '0) && !redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_pend;
    logic fault_push;

    assign target = redirect_pc;
    // In FAULT nothing new is requested, so discard == 0 means the memory side is idle.
    assign fault_push = fault_pend && (discard == '0) && !redirect_valid
                     && (fifo_count != CW'(DEPTH));
    assign push       = accept || fault_push;
    assign push_data  = fault_push ? '{instr: INSTR_NOP, pc: fetch_pc, misaligned: 1'b1}
                                   : '{instr: imem_rdata, pc: resp_pc, misaligned: 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_pend <= 1'b0;
        end else if (redirect_valid) begin
            fault_pend <= |redirect_pc[1:0];
        end else if (fault_push) begin
            fault_pend <= 1'b0;
        end
    end
`else
    assign target    = redirect_pc & ~32'h3;
    assign push      = accept;
    assign push_data = '{instr: imem_rdata, pc: resp_pc, misaligned: 1'b0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = fetch_en ? RUN : IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (|redirect_pc[1:0]) begin
                state_nxt = FAULT;
            end
`endif
        end else begin
            case (state)
                IDLE:    if (fetch_en)  state_nxt = RUN;
                RUN:     if (!fetch_en) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + OW'(gnt_fire) - OW'(imem_rvalid);
            if (redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                // Everything still in flight after this cycle is stale.
                discard  <= outstanding - OW'(imem_rvalid);
            end else begin
                if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
                if (accept)   resp_pc  <= resp_pc + 32'd4;
                if (drop)     discard  <= discard - 1'b1;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (instr_ready),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign instr_valid      = !fifo_empty;
    assign instruction      = head.instr;
    assign pc               = head.pc;
    // Always 0 without the misalign check: no entry is ever pushed with the flag set.
    assign instr_misaligned = head.misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_misaligned;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .pc(pc), .instr_misaligned(instr_misaligned)
    );

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } ent_t;

    mreq_t       inflight[$];   // memory: granted, not yet answered
    ent_t        mq[$];         // expected decode-visible contents
    logic [31:0] popped[$];     // pcs delivered to decode
    int          cyc, epoch, mem_lat, grants, first_iv, passed, fails, total;
    bit          rand_mem;
    logic [31:0] exp_issue, fault_pc;
    logic        post_redir, in_fault, fault_pend;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] first_popped();
        return (popped.size() > 0) ? popped[0] : 32'hxxxx_xxxx;
    endfunction

    task automatic drive_mem();
        imem_gnt = rand_mem ? ($urandom_range(3) != 0) : 1'b1;
        if (inflight.size() > 0 && inflight[0].due <= cyc && (!rand_mem || $urandom_range(1) == 1)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~inflight[0].addr;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    task automatic tick();
        logic s_req, s_gnt, s_rv, s_iv, s_ir, s_redir, s_mis;
        logic [31:0] s_addr, s_pc, s_ins, s_rpc;
        int live;
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_gnt = imem_gnt; s_rv = imem_rvalid;
        s_iv = instr_valid; s_ir = instr_ready; s_pc = pc; s_ins = instruction; s_mis = instr_misaligned;
        s_redir = redirect_valid; s_rpc = redirect_pc;
        live = 0;
        foreach (inflight[i]) if (inflight[i].epoch == epoch) live++;

        check("instr_valid", s_iv, mq.size() > 0);
        if (post_redir) check("valid_after_redirect", s_iv, 1'b0);
        if (s_redir) check("req_during_redirect", s_req, 1'b0);
        if (in_fault) check("req_in_fault", s_req, 1'b0);
        if (s_req) begin
            check("outstanding_limit", inflight.size() < MAXO, 1'b1);
            check("fifo_space", (mq.size() + live) < DEPTH, 1'b1);
        end
        if (s_req && s_gnt) begin
            check("issue_addr", s_addr, exp_issue);
            exp_issue += 32'd4;
            grants++;
        end
        if (s_iv && s_ir && !s_redir && mq.size() > 0) begin
            check("pop_entry", {s_pc, s_ins, s_mis}, {mq[0].pc, mq[0].instr, mq[0].mis});
            popped.push_back(s_pc);
            void'(mq.pop_front());
        end
        if (s_rv && !s_redir && inflight.size() > 0 && inflight[0].epoch == epoch)
            mq.push_back('{inflight[0].addr, ~inflight[0].addr, 1'b0});
        if (fault_pend && !s_redir && inflight.size() == 0) begin
            mq.push_back('{fault_pc, INSTR_NOP, 1'b1});
            fault_pend = 1'b0;
        end
        if (s_redir) begin
            mq.delete();
            epoch++;
`ifdef FETCH_MISALIGN_CHECK_EN
            in_fault   = (s_rpc[1:0] != 2'b00);
            fault_pend = in_fault;
            fault_pc   = s_rpc;
            exp_issue  = s_rpc;
`else
            exp_issue  = s_rpc & ~32'h3;
`endif
        end
        post_redir = s_redir;
        if (first_iv < 0 && s_iv) first_iv = cyc;

        @(posedge clk);
        #1;
        cyc++;
        if (s_rv && inflight.size() > 0) void'(inflight.pop_front());
        if (s_req && s_gnt) inflight.push_back('{s_addr, cyc + mem_lat - 1, epoch});
        drive_mem();
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rvalid = 1'b0; imem_gnt = 1'b0; imem_rdata = 32'h0;
        inflight.delete(); mq.delete(); popped.delete();
        epoch = 0; exp_issue = 32'h0; post_redir = 1'b0; in_fault = 1'b0; fault_pend = 1'b0;
        first_iv = -1; grants = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {imem_req, imem_addr, instr_valid, instruction, pc, instr_misaligned},
              {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        drive_mem();
    endtask

    initial begin
        int found, m0;
        rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        passed = 0; fails = 0; total = 0; mem_lat = 1; rand_mem = 0;

        // Latency and stall: ready low from reset, 1-cycle memory.
        fetch_en = 1'b1;
        do_reset();
        repeat (14) tick();
        check("first_valid_cycle", first_iv, 3);
        check("buffered_depth", mq.size(), DEPTH);
        check("grants_when_full", grants, DEPTH);
        check("req_stalled", imem_req, 1'b0);
        instr_ready = 1'b1;
        repeat (10) tick();
        check("resume_count", popped.size() >= 5, 1'b1);
        if (popped.size() >= 5)
            check("resume_order", {popped[0], popped[3], popped[4]}, {32'h0, 32'hC, 32'h10});

        // Redirect while 0x8 is returning and 0xC is still outstanding.
        mem_lat = 2;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (imem_rvalid && inflight.size() == 2 && inflight[0].addr == 32'h8) found = 1;
            else tick();
        end
        check("redir_setup", found, 1);
        if (found == 1) check("redir_second_outstanding", inflight[1].addr, 32'hC);
        popped.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
        check("redir_first_pc", first_popped(), 32'h100);

        // Back-to-back redirects: last one wins.
        popped.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
        check("b2b_first_pc", first_popped(), 32'h300);

        // Misaligned redirect target.
        popped.delete();
        grants = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
`ifdef FETCH_MISALIGN_CHECK_EN
        check("fault_entry", {32'(popped.size()), first_popped()}, {32'd1, 32'h102});
        check("fault_no_grants", grants, 0);
        popped.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
        check("fault_exit_pc", first_popped(), 32'h200);
`else
        check("align_first_pc", first_popped(), 32'h100);
`endif

        // fetch_en dropped with two requests outstanding.
        mem_lat = 3;
        instr_ready = 1'b0;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (inflight.size() == 2) found = 1;
            else tick();
        end
        check("fetch_off_setup", found, 1);
        fetch_en = 1'b0;
        m0 = mq.size();
        grants = 0;
        repeat (12) tick();
        check("fetch_off_landed", {32'(grants), 32'(mq.size())}, {32'd0, 32'(m0 + 2)});
        check("fetch_off_req", imem_req, 1'b0);

        // Randomised traffic: random grants, latency, ready, fetch_en and redirects (incl. wrap).
        rand_mem = 1;
        fetch_en = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) mem_lat = $urandom_range(3, 1);
            instr_ready    = ($urandom_range(3) != 0);
            fetch_en       = ($urandom_range(15) != 0);
            redirect_valid = ($urandom_range(24) == 0);
            case ($urandom_range(3))
                0:       redirect_pc = 32'hFFFF_FFF8;
                1:       redirect_pc = $urandom;
                default: redirect_pc = $urandom & ~32'h3;
            endcase
            tick();
        end
        redirect_valid = 1'b0;

        // Reset in the middle of traffic, then clean restart from RESET_PC.
        rand_mem = 0;
        mem_lat = 1;
        instr_ready = 1'b1;
        fetch_en = 1'b1;
        do_reset();
        repeat (20) tick();
        check("post_reset_first_pc", first_popped(), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
